// File: rtl/rmt_recovery_walker_if.sv
// -----------------------------------------------------------------------------
// rmt_recovery_walker_if
//   Bundles every non-clock signal of the RMT recovery walker.
//
//   Handshake semantics: there is no backpressure anywhere on this bundle.
//   - toRecoveryPhase is a one-cycle pulse. flushRangeHeadPtr and
//     flushRangeTailPtr are only meaningful in the cycle of that pulse.
//   - alReadEn/alReadPtr is a fire-and-forget read request. The ActiveList
//     returns alRead* data in the following cycle.
//   - rmtWriteEn and freeListPushEn are single-cycle strobes. They are always
//     accepted by the consumer in the cycle they are high.
//   - recoveryBusy is a level signal. It is high for the whole recovery walk.
//
//   Modports:
//     slave  : the walker itself (consumes pulse and read data, drives writes)
//     master : the environment (recovery manager, ActiveList, RMT, free list)
// -----------------------------------------------------------------------------
interface rmt_recovery_walker_if #(
  parameter int AL_ENTRY_NUM = 64,
  parameter int LOG_REG_NUM  = 32,
  parameter int PHY_REG_NUM  = 128
);
  localparam int PTR_W  = $clog2(AL_ENTRY_NUM);
  localparam int LREG_W = $clog2(LOG_REG_NUM);
  localparam int PREG_W = $clog2(PHY_REG_NUM);

  // recovery manager -> walker
  logic              toRecoveryPhase;
  logic [PTR_W-1:0]  flushRangeHeadPtr;
  logic [PTR_W-1:0]  flushRangeTailPtr;

  // walker <-> ActiveList read port
  logic [PTR_W-1:0]  alReadPtr;
  logic              alReadEn;
  logic              alReadWriteReg;
  logic [LREG_W-1:0] alReadLogReg;
  logic [PREG_W-1:0] alReadPhyReg;
  logic [PREG_W-1:0] alReadPrevPhyReg;

  // walker -> RMT / free list
  logic              rmtWriteEn;
  logic [LREG_W-1:0] rmtWriteLogReg;
  logic [PREG_W-1:0] rmtWritePhyReg;
  logic              freeListPushEn;
  logic [PREG_W-1:0] freeListPushReg;

  // walker -> recovery manager
  logic              recoveryBusy;

  modport slave (
    input  toRecoveryPhase, flushRangeHeadPtr, flushRangeTailPtr,
    input  alReadWriteReg, alReadLogReg, alReadPhyReg, alReadPrevPhyReg,
    output alReadPtr, alReadEn,
    output rmtWriteEn, rmtWriteLogReg, rmtWritePhyReg,
    output freeListPushEn, freeListPushReg,
    output recoveryBusy
  );

  modport master (
    output toRecoveryPhase, flushRangeHeadPtr, flushRangeTailPtr,
    output alReadWriteReg, alReadLogReg, alReadPhyReg, alReadPrevPhyReg,
    input  alReadPtr, alReadEn,
    input  rmtWriteEn, rmtWriteLogReg, rmtWritePhyReg,
    input  freeListPushEn, freeListPushReg,
    input  recoveryBusy
  );
endinterface

// File: rtl/rmt_recovery_walker.sv
// -----------------------------------------------------------------------------
// rmt_recovery_walker
//   Rename-stage responder to the recovery broadcast. On a recovery pulse it
//   walks the flushed ActiveList range from the youngest entry to the oldest
//   entry. For every flushed op that wrote a register, it restores the old
//   logical->physical mapping in the RMT. It also returns the physical
//   register of that op to the free list.
//
// Ports:
//   clk           : clock
//   rst           : synchronous active-high reset
//   bus           : rmt_recovery_walker_if.slave. It carries the recovery
//                   pulse and range, the ActiveList read port, the RMT and
//                   free-list write strobes, and recoveryBusy.
//   o_dbg_state   : current FSM state (IDLE/WALK/DRAIN/DONE)
//   o_dbg_head    : latched oldest flushed index (inclusive)
//   o_dbg_tail    : latched one-past-youngest flushed index (exclusive)
//   o_dbg_cursor  : next ActiveList index to be read
//   o_dbg_dvalid  : read data is expected on the ActiveList port this cycle
// -----------------------------------------------------------------------------
module rmt_recovery_walker #(
  parameter int AL_ENTRY_NUM = 64,
  parameter int LOG_REG_NUM  = 32,
  parameter int PHY_REG_NUM  = 128,
  localparam int PTR_W  = $clog2(AL_ENTRY_NUM),
  localparam int LREG_W = $clog2(LOG_REG_NUM),
  localparam int PREG_W = $clog2(PHY_REG_NUM)
) (
  input  logic                 clk,
  input  logic                 rst,
  rmt_recovery_walker_if.slave bus,
  output logic [1:0]           o_dbg_state,
  output logic [PTR_W-1:0]     o_dbg_head,
  output logic [PTR_W-1:0]     o_dbg_tail,
  output logic [PTR_W-1:0]     o_dbg_cursor,
  output logic                 o_dbg_dvalid
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WALK  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};

  logic [1:0]       r_state;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W-1:0] r_cursor;
  // High in the cycle that the ActiveList returns data for a read that
  // was issued in the previous cycle.
  logic             r_data_valid;

  logic             w_walk;
  logic             w_last_read;
  logic             w_start;
  logic             w_empty;
  logic             w_restore;

  assign w_walk      = (r_state == ST_WALK);
  // The read that targets the latched head is the final read of the walk.
  assign w_last_read = w_walk && (r_cursor == r_head);
  assign w_start     = (r_state == ST_IDLE) && bus.toRecoveryPhase;
  assign w_empty     = (bus.flushRangeHeadPtr == bus.flushRangeTailPtr);
  assign w_restore   = r_data_valid && bus.alReadWriteReg;

  // ---------------------------------------------------------------------------
  // Control: FSM, latched range, walk cursor, and data-valid pipeline
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_head       <= '0;
      r_tail       <= '0;
      r_cursor     <= '0;
      r_data_valid <= 1'b0;
    end else begin
      r_data_valid <= w_walk;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_head   <= bus.flushRangeHeadPtr;
            r_tail   <= bus.flushRangeTailPtr;
            // Youngest flushed entry is one below the exclusive tail. The
            // decrement wraps, which is the ring-buffer behavior we need.
            r_cursor <= bus.flushRangeTailPtr - PTR_ONE;
            r_state  <= w_empty ? ST_DONE : ST_WALK;
          end
        end
        ST_WALK: begin
          r_cursor <= r_cursor - PTR_ONE;
          if (w_last_read) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // The data for the last read is consumed in this cycle through
          // r_data_valid. The FSM only needs to step on.
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. The read port is driven only while walking. The write strobes
  // are combinational from the returned data, qualified by r_data_valid.
  // The data buses are forced to zero when their strobe is low.
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.alReadEn        = w_walk;
    bus.alReadPtr       = w_walk ? r_cursor : '0;
    bus.rmtWriteEn      = w_restore;
    bus.rmtWriteLogReg  = w_restore ? bus.alReadLogReg     : '0;
    bus.rmtWritePhyReg  = w_restore ? bus.alReadPrevPhyReg : '0;
    bus.freeListPushEn  = w_restore;
    bus.freeListPushReg = w_restore ? bus.alReadPhyReg     : '0;
    bus.recoveryBusy    = (r_state != ST_IDLE);
  end

  assign o_dbg_state  = r_state;
  assign o_dbg_head   = r_head;
  assign o_dbg_tail   = r_tail;
  assign o_dbg_cursor = r_cursor;
  assign o_dbg_dvalid = r_data_valid;

`ifndef SYNTHESIS
  // A new recovery pulse while a walk is in flight is ignored by the FSM
  // above. It still indicates a broken recovery manager, so report it.
  always_ff @(posedge clk) begin
    if (!rst && bus.toRecoveryPhase) begin
      assert (r_state == ST_IDLE)
        else $error("rmt_recovery_walker: toRecoveryPhase while busy");
    end
  end
`endif

endmodule
